bram_sweep_checker: RTL and testbench
=====================================

# bram_sweep_checker

Self-checking BRAM sweep engine for power-analysis stress designs: writes a full-address-range data pattern through a write port, reads every location back through a read port, and compares each word against the expected value. It runs two rounds, the pattern and then its bitwise inverse, so every stored bit toggles. It complements the fixed-address ping-pong BRAM testers by verifying the whole array. Multiple instances are tiled under a top that ANDs their `pass` outputs.

## Interface
- `ID`, 0: instance number, used only in simulation `$display` messages.
- `A_WID`, 10: address width; N = 2^A_WID words.
- `D_WID`, 8: data width, 1..32.
- `SEED`, 'hA5: pattern seed, truncated to D_WID.
- `READ_LAT`, 1: BRAM read latency in cycles, 1 or 2.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  begin a test; sampled in IDLE or DONE only.
- `enable`  in  1  advance qualifier; when low, the whole block stalls.
- `inject_err`  in  1  when high, flips bit 0 of the read data before compare.
- `busy`  out  1  high from WRITE through the last DRAIN.
- `done`  out  1  high in DONE.
- `pass`  out  1  high in DONE when `err_cnt == 0`.
- `err_cnt`  out  16  mismatch count; saturates at 16'hFFFF.

## Operation
- Expected data: `exp(a, r) = (a[D_WID-1:0] ^ SEED) ^ {D_WID{r}}`.
  - `a` is zero-extended when A_WID < D_WID.
  - `r` is the round bit, 0 or 1.
- FSM states: IDLE, WRITE, READ, DRAIN, DONE.
  - IDLE: if `start`, clear `err_cnt`, set round=0, set addr=0, go to WRITE.
  - WRITE: on each `enable` cycle, write `exp(addr, round)` to `addr`. When addr = N-1, wrap addr to 0 and go to READ.
  - READ: on each `enable` cycle, issue a read of `addr`. When addr = N-1, wrap and go to DRAIN.
  - DRAIN: stay READ_LAT enabled cycles so in-flight reads retire. Then, if round==0, set round=1 and go to WRITE; else go to DONE.
  - DONE: hold all outputs. `start` acts as in IDLE and restarts the test.
- `start` is ignored while `busy`.
- Compare pipeline:
  - A valid/addr/round shift register of depth READ_LAT runs alongside the BRAM.
  - At the output stage, if valid and `dout ^ {inject_err}` ≠ exp, increment `err_cnt` (saturating).
  - In simulation, a mismatch also prints ID, time, address, read data and expected data.
- `enable` low:
  - FSM, address counter and compare pipeline freeze.
  - BRAM port enables are driven low, so the read data register holds.
- A `rst` in any state forces IDLE, sets all outputs to 0 and clears counters. BRAM contents are not cleared.

## Timing
- Reset values: `busy`=0, `done`=0, `pass`=0, `err_cnt`=0.
- All outputs are registered.
- The cycle after `start` is sampled is the first WRITE cycle.
- One round takes 2N + READ_LAT enabled cycles.
- With `enable` held high, `done` rises 2·(2N+READ_LAT)+1 cycles after the `start` sample. For A_WID=10 and READ_LAT=1, that is cycle 4099.
- Read-after-write: the first READ of a round follows the last WRITE of that round by 1 cycle. The BRAM is write-first, so there is no hazard across ports.
- `err_cnt` is updated READ_LAT+1 cycles after the corresponding read issue.
- `busy` falls and `done`/`pass` rise in the same cycle.

## Structure
- Package `bram_test_pkg` holds:
  - the state enum (`st_idle`, `st_write`, `st_read`, `st_drain`, `st_done`);
  - the function `exp_word(addr, round, seed)`;
  - the constant `ERR_W = 16`.
- Sub-module `bram_sdp`:
  - simple dual port: port A write-only, port B read-only;
  - common `clk`, registered output, READ_LAT pipeline stages;
  - has `(* ram_style = "block" *)` and infers block RAM.
- The sweep FSM, address counter, compare pipeline and error counter sit in `bram_sweep_checker`.

## Test plan
- Reset then `start`, with A_WID=4, READ_LAT=1, `enable`=1 throughout → `done` and `pass` rise at cycle 2·(32+1)+1 = 67, with `err_cnt` = 0.
- Same run with `inject_err`=1 for exactly 3 READ-state cycles in round 1 → `done` rises, `pass`=0, `err_cnt`=3, and three mismatch messages are printed.
- Toggle `enable` pseudo-randomly at 50% → identical final result to the first scenario. Completion cycle = 67 enabled cycles. `err_cnt` does not change during stalls.
- Assert `rst` mid-READ of round 0 → next cycle all outputs are 0 and the state is IDLE. A subsequent `start` produces a clean pass.
- Pulse `start` while `busy` → ignored, and the completion cycle is unchanged. `start` in DONE → restart, with `err_cnt` cleared on the next cycle.
- Set READ_LAT=2 with `inject_err` held high during all reads → `err_cnt` = 2·N = 32. Saturation at 16'hFFFF is checked with a forced counter preload.

Source files
------------

// File: rtl/bram_test_pkg.sv
`default_nettype none
// ============================================================================
// Package  : bram_test_pkg
// Brief    : Shared state encoding, constants and pattern function for the
//            BRAM sweep checker.
// Revision : 1.0 - initial release
// ============================================================================
package bram_test_pkg;

    localparam int ERR_W = 16;

    typedef enum logic [2:0] {
        st_idle  = 3'd0,
        st_write = 3'd1,
        st_read  = 3'd2,
        st_drain = 3'd3,
        st_done  = 3'd4
    } state_t;

    // Full 32-bit pattern word; callers keep the low D_WID bits.
    function automatic logic [31:0] exp_word(
        input logic [31:0] addr,
        input logic        round,
        input logic [31:0] seed
    );
        return (addr ^ seed) ^ {32{round}};
    endfunction

endpackage
`default_nettype wire

// File: rtl/bram_sweep_checker_if.sv
`default_nettype none
// ============================================================================
// Module   : bram_sweep_checker_if
// Brief    : Control/status bundle between a sweep checker and its driver.
// Revision : 1.0 - initial release
// ============================================================================
interface bram_sweep_checker_if;
    import bram_test_pkg::*;

    logic             start;
    logic             enable;
    logic             inject_err;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_cnt;

    modport master (
        output start, enable, inject_err,
        input  busy, done, pass, err_cnt
    );

    modport slave (
        input  start, enable, inject_err,
        output busy, done, pass, err_cnt
    );

endinterface
`default_nettype wire

// File: rtl/bram_sdp.sv
`default_nettype none
// ============================================================================
// Module   : bram_sdp
// Brief    : Simple dual-port block RAM, write-only port A, read-only port B,
//            registered output with READ_LAT stages.
// Revision : 1.0 - initial release
// ============================================================================
module bram_sdp #(
    parameter int A_WID    = 10,
    parameter int D_WID    = 8,
    parameter int READ_LAT = 1
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [A_WID-1:0] i_waddr,
    input  logic [D_WID-1:0] i_wdata,
    input  logic             i_re,
    input  logic [A_WID-1:0] i_raddr,
    output logic [D_WID-1:0] o_rdata
);

    (* ram_style = "block" *) logic [D_WID-1:0] r_mem [0:(1<<A_WID)-1];
    logic [D_WID-1:0] r_rd0;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Write-first on a same-address collision between the two ports.
    always_ff @(posedge clk) begin
        if (i_re) begin
            r_rd0 <= (i_we && (i_waddr == i_raddr)) ? i_wdata : r_mem[i_raddr];
        end
    end

    generate
        if (READ_LAT == 2) begin : g_lat2
            logic [D_WID-1:0] r_rd1;
            always_ff @(posedge clk) begin
                if (i_re) begin
                    r_rd1 <= r_rd0;
                end
            end
            assign o_rdata = r_rd1;
        end else begin : g_lat1
            assign o_rdata = r_rd0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/bram_sweep_checker.sv
`default_nettype none
// ============================================================================
// Module   : bram_sweep_checker
// Brief    : Two-round (pattern, then inverse) full-array BRAM write / read /
//            compare sweep with saturating mismatch counter.
// Revision : 1.0 - initial release
// ============================================================================
module bram_sweep_checker
    import bram_test_pkg::*;
#(
    parameter int          ID       = 0,
    parameter int          A_WID    = 10,
    parameter int          D_WID    = 8,
    parameter logic [31:0] SEED     = 32'hA5,
    parameter int          READ_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    bram_sweep_checker_if.slave ctl
);

    localparam logic [A_WID-1:0] c_LAST_ADDR  = '1;
    localparam logic             c_DRAIN_LAST = (READ_LAT == 2);

    generate
        if (D_WID < 1 || D_WID > 32 || (READ_LAT != 1 && READ_LAT != 2)) begin : g_param_chk
            $error("bram_sweep_checker %0d: unsupported D_WID/READ_LAT", ID);
        end
    endgenerate

    state_t              r_state;
    logic [A_WID-1:0]    r_addr;
    logic                r_round;
    logic                r_drain;
    logic                r_busy;
    logic                r_done;
    logic                r_pass;
    logic [ERR_W-1:0]    r_err_cnt;

    // Compare pipeline tracking reads in flight through the RAM.
    logic [READ_LAT-1:0] r_pv;
    logic [READ_LAT-1:0] r_pr;
    logic [A_WID-1:0]    r_pa [READ_LAT];

    logic [31:0]         w_wr_full;
    logic [31:0]         w_cmp_full;
    logic [D_WID-1:0]    w_rdata;
    logic [D_WID-1:0]    w_rdata_chk;
    logic                w_we;
    logic                w_mis;
    logic [ERR_W-1:0]    w_err_next;

    assign w_wr_full   = exp_word(32'(r_addr), r_round, SEED);
    assign w_cmp_full  = exp_word(32'(r_pa[READ_LAT-1]), r_pr[READ_LAT-1], SEED);
    assign w_we        = ctl.enable && (r_state == st_write);
    assign w_rdata_chk = w_rdata ^ D_WID'(ctl.inject_err);
    assign w_mis       = r_pv[READ_LAT-1] && (w_rdata_chk != w_cmp_full[D_WID-1:0]);
    assign w_err_next  = (w_mis && (r_err_cnt != '1)) ? r_err_cnt + 1'b1 : r_err_cnt;

    generate
        if (D_WID < 32) begin : g_unused_hi
            logic w_unused_hi;
            assign w_unused_hi = ^{w_wr_full[31:D_WID], w_cmp_full[31:D_WID]};
        end
    endgenerate

    bram_sdp #(
        .A_WID    (A_WID),
        .D_WID    (D_WID),
        .READ_LAT (READ_LAT)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_addr),
        .i_wdata (w_wr_full[D_WID-1:0]),
        .i_re    (ctl.enable),
        .i_raddr (r_addr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= st_idle;
            r_addr    <= '0;
            r_round   <= 1'b0;
            r_drain   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
            r_err_cnt <= '0;
            r_pv      <= '0;
        end else if (ctl.enable) begin
            r_err_cnt <= w_err_next;
            r_pv[0]   <= (r_state == st_read);
            r_pa[0]   <= r_addr;
            r_pr[0]   <= r_round;
            for (int i = 1; i < READ_LAT; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pa[i] <= r_pa[i-1];
                r_pr[i] <= r_pr[i-1];
            end

            case (r_state)
                st_idle, st_done: begin
                    if (ctl.start) begin
                        r_err_cnt <= '0;
                        r_round   <= 1'b0;
                        r_addr    <= '0;
                        r_busy    <= 1'b1;
                        r_done    <= 1'b0;
                        r_pass    <= 1'b0;
                        r_state   <= st_write;
                    end
                end
                st_write: begin
                    r_addr <= r_addr + 1'b1;
                    if (r_addr == c_LAST_ADDR) begin
                        r_state <= st_read;
                    end
                end
                st_read: begin
                    r_addr <= r_addr + 1'b1;
                    if (r_addr == c_LAST_ADDR) begin
                        r_drain <= 1'b0;
                        r_state <= st_drain;
                    end
                end
                st_drain: begin
                    if (r_drain == c_DRAIN_LAST) begin
                        if (!r_round) begin
                            r_round <= 1'b1;
                            r_state <= st_write;
                        end else begin
                            // Last compare retires on this edge, so judge the next count.
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (w_err_next == '0);
                            r_state <= st_done;
                        end
                    end else begin
                        r_drain <= 1'b1;
                    end
                end
                default: r_state <= st_idle;
            endcase
        end
    end

    assign ctl.busy    = r_busy;
    assign ctl.done    = r_done;
    assign ctl.pass    = r_pass;
    assign ctl.err_cnt = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_bram_sweep_checker.sv
`timescale 1ns/1ps
// Scoreboarded bench for bram_sweep_checker: one READ_LAT=1 and one
// READ_LAT=2 instance, each with a 16-word array.
module tb_bram_sweep_checker;
    import bram_test_pkg::*;

    localparam int          A_WID = 4;
    localparam int          D_WID = 8;
    localparam int          N     = 1 << A_WID;
    localparam logic [31:0] SEED  = 32'hA5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bram_sweep_checker_if if1();
    bram_sweep_checker_if if2();

    bram_sweep_checker #(.ID(1), .A_WID(A_WID), .D_WID(D_WID), .SEED(SEED), .READ_LAT(1))
        dut1 (.clk(clk), .rst(rst), .ctl(if1));
    bram_sweep_checker #(.ID(2), .A_WID(A_WID), .D_WID(D_WID), .SEED(SEED), .READ_LAT(2))
        dut2 (.clk(clk), .rst(rst), .ctl(if2));

    typedef struct {
        int          mark;
        int          cyc;
        logic [15:0] err;
        logic        pass;
    } exp_t;

    exp_t        sb_q[$];
    int          vectors     = 0;
    int          miscompares = 0;
    int          en_cyc   [2] = '{0, 0};
    logic        en_last  [2] = '{1'b0, 1'b0};
    logic        done_prev[2] = '{1'b0, 1'b0};
    logic [15:0] err_prev [2] = '{16'h0, 16'h0};
    logic        rst_last = 1'b1;

    // ---------------- reference model ----------------
    function automatic logic [7:0] ref_word(input int a, input int r);
        int v;
        v = (a % 256) ^ int'(SEED & 32'hFF);
        if (r != 0) v = ~v;
        return 8'(v);
    endfunction

    // Read of address a in round r is issued (2N+rl)*r + N + 1 + a edges after
    // the start edge and judged rl edges later; inject counts where it overlaps.
    function automatic int model_errs(input int rl, input int lo, input int hi);
        int n = 0;
        for (int r = 0; r < 2; r++) begin
            for (int a = 0; a < N; a++) begin
                int e = r * (2 * N + rl) + N + 1 + a + rl;
                if (e >= lo && e <= hi) n++;
            end
        end
        return (n > 65535) ? 65535 : n;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", name, got, want);
        end
    endtask

    // ---------------- monitor ----------------
    always @(posedge clk) begin
        en_last[0] = if1.enable;
        en_last[1] = if2.enable;
        rst_last   = rst;
        if (if1.enable) en_cyc[0]++;
        if (if2.enable) en_cyc[1]++;
    end

    task automatic mon(input int d, input logic dn, input logic ps, input logic bz,
                       input logic [15:0] ec);
        exp_t       e;
        logic [7:0] w;
        logic [3:0] ai;
        if (!rst && !rst_last) begin
            if (!en_last[d] && bz)
                chk($sformatf("stall_hold_dut%0d", d), 32'(ec), 32'(err_prev[d]));
            if (dn && !done_prev[d]) begin
                if (sb_q.size() == 0) begin
                    chk($sformatf("unexpected_done_dut%0d", d), 32'(dn), 32'h0);
                end else begin
                    e = sb_q.pop_front();
                    chk($sformatf("done_cycle_dut%0d", d), 32'(en_cyc[d] - e.mark), 32'(e.cyc));
                    chk($sformatf("err_cnt_dut%0d", d), 32'(ec), 32'(e.err));
                    chk($sformatf("pass_dut%0d", d), 32'(ps), 32'(e.pass));
                    chk($sformatf("busy_at_done_dut%0d", d), 32'(bz), 32'h0);
                    for (int a = 0; a < N; a++) begin
                        ai = 4'(a);
                        w  = (d == 0) ? dut1.u_ram.r_mem[ai] : dut2.u_ram.r_mem[ai];
                        chk($sformatf("mem_dut%0d_a%0d", d, a), 32'(w), 32'(ref_word(a, 1)));
                    end
                end
            end
        end
        done_prev[d] = dn;
        err_prev[d]  = ec;
    endtask

    always @(negedge clk) begin
        mon(0, if1.done, if1.pass, if1.busy, if1.err_cnt);
        mon(1, if2.done, if2.pass, if2.busy, if2.err_cnt);
    end

    // ---------------- stimulus ----------------
    task automatic drive(input int d, input logic s, input logic en, input logic inj);
        if (d == 0) begin
            if1.start = s; if1.enable = en; if1.inject_err = inj;
        end else begin
            if2.start = s; if2.enable = en; if2.inject_err = inj;
        end
    endtask

    // One full test: start edge is edge 0; inject is high on edges inj_lo..inj_hi.
    task automatic run(input int d, input int rl, input bit rand_en, input int inj_lo,
                       input int inj_hi, input int busy_pulse, input bit chk_restart,
                       input int force_at);
        exp_t e;
        @(negedge clk);
        drive(d, 1'b1, 1'b1, (inj_lo <= 0 && inj_hi >= 0));
        e.mark = en_cyc[d];
        e.cyc  = 2 * (2 * N + rl) + 1;
        e.err  = (force_at > 0) ? 16'hFFFF : 16'(model_errs(rl, inj_lo, inj_hi));
        e.pass = (e.err == 16'h0);
        sb_q.push_back(e);
        for (int i = 1; i <= 2000 && sb_q.size() != 0; i++) begin
            @(negedge clk);
            if (chk_restart && i == 1) begin
                chk("restart_err_clear", 32'((d == 0) ? if1.err_cnt : if2.err_cnt), 32'h0);
                chk("restart_done_low", 32'((d == 0) ? if1.done : if2.done), 32'h0);
                chk("restart_busy_high", 32'((d == 0) ? if1.busy : if2.busy), 32'h1);
            end
            if (force_at > 0 && i == force_at) begin
                drive(d, 1'b0, 1'b0, 1'b1);
                @(negedge clk);
                #2 force dut2.r_err_cnt = 16'hFFFD;
                #1 release dut2.r_err_cnt;
                drive(d, 1'b0, 1'b1, 1'b1);
            end else begin
                drive(d, (i == busy_pulse),
                      rand_en ? 1'($urandom_range(1, 0)) : 1'b1,
                      (i >= inj_lo && i <= inj_hi));
            end
        end
        if (sb_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL timeout_dut%0d: done not seen, %0d pending, required 0", d, sb_q.size());
            sb_q.delete();
        end
        drive(d, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        int k0;
        drive(0, 1'b0, 1'b1, 1'b0);
        drive(1, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", 32'(if1.busy), 32'h0);
        chk("reset_done", 32'(if1.done), 32'h0);
        chk("reset_pass", 32'(if1.pass), 32'h0);
        chk("reset_err",  32'(if1.err_cnt), 32'h0);
        chk("reset_busy2", 32'(if2.busy), 32'h0);
        chk("reset_err2",  32'(if2.err_cnt), 32'h0);

        // Clean run, enable held high.
        run(0, 1, 1'b0, -1, -1, 0, 1'b0, 0);
        // Three inject edges inside round-1 compares.
        k0 = $urandom_range(62, 52);
        run(0, 1, 1'b0, k0, k0 + 2, 0, 1'b0, 0);
        // Restart from DONE with random stalls.
        run(0, 1, 1'b1, -1, -1, 0, 1'b1, 0);
        // start pulse while busy must be ignored.
        run(0, 1, 1'b0, -1, -1, 20, 1'b0, 0);

        // Reset in round-0 READ with errors already counted.
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 1'b1);
        for (int i = 1; i < 24; i++) begin
            @(negedge clk);
            drive(0, 1'b0, 1'b1, 1'b1);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drive(0, 1'b0, 1'b1, 1'b0);
        chk("midrst_busy", 32'(if1.busy), 32'h0);
        chk("midrst_done", 32'(if1.done), 32'h0);
        chk("midrst_pass", 32'(if1.pass), 32'h0);
        chk("midrst_err",  32'(if1.err_cnt), 32'h0);
        repeat (5) @(negedge clk);
        chk("midrst_idle_busy", 32'(if1.busy), 32'h0);
        run(0, 1, 1'b0, -1, -1, 0, 1'b0, 0);

        // READ_LAT=2 with inject held throughout, then saturation.
        run(1, 2, 1'b0, 0, 100000, 0, 1'b0, 0);
        run(1, 2, 1'b0, 0, 100000, 0, 1'b0, 56);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
